// File: rtl/tone_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tone_seq_pkg
// Brief   : Shared types and default widths for the tone sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package tone_seq_pkg;

    localparam int c_SEQ_LEN_DEF     = 8;
    localparam int c_PERIOD_W_DEF    = 32;
    localparam int c_DUR_W_DEF       = 16;
    localparam int c_TICK_CYCLES_DEF = 50000;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    // Step record layout at the default widths; the top re-declares it at
    // its own parameterised widths.
    typedef struct packed {
        logic [c_PERIOD_W_DEF-1:0] period;
        logic [c_DUR_W_DEF-1:0]    dur;
    } step_rec_t;

endpackage
`default_nettype wire

// File: rtl/tone_gen.sv
`default_nettype none
// ============================================================================
// Module  : tone_gen
// Brief   : Per-step square-wave generator. Counts 0..period-1 and toggles
//           the output on the last count; period 0 holds the output low.
//           restart clears the counter and the output.
// Revision: 1.0 - initial release
// ============================================================================
module tone_gen
    import tone_seq_pkg::*;
#(
    parameter int PERIOD_W = c_PERIOD_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PERIOD_W-1:0] period,
    input  logic                restart,
    output logic                jack
);

    logic [PERIOD_W-1:0] r_cnt_q;
    logic [PERIOD_W-1:0] w_cnt_d;
    logic                r_jack_q;
    logic                w_jack_d;
    logic                w_wrap;

    // Next counter / output value: restart and rest both force a quiet line.
    always_comb begin
        w_cnt_d  = r_cnt_q;
        w_jack_d = r_jack_q;
        w_wrap   = (period != '0) && (r_cnt_q == period - PERIOD_W'(1));
        if (restart || (period == '0)) begin
            w_cnt_d  = '0;
            w_jack_d = 1'b0;
        end else if (w_wrap) begin
            w_cnt_d  = '0;
            w_jack_d = ~r_jack_q;
        end else begin
            w_cnt_d  = r_cnt_q + PERIOD_W'(1);
        end
    end

    // Counter and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt_q  <= '0;
            r_jack_q <= 1'b0;
        end else begin
            r_cnt_q  <= w_cnt_d;
            r_jack_q <= w_jack_d;
        end
    end

    assign jack = r_jack_q;

endmodule
`default_nettype wire

// File: rtl/tone_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tone_sequencer
// Brief   : Programmable tone player. Walks a writable table of
//           (half_period, duration) steps, one-shot or looping, driving a
//           square wave on jack.
// Revision: 1.0 - initial release
// ============================================================================
module tone_sequencer
    import tone_seq_pkg::*;
#(
    parameter int SEQ_LEN     = c_SEQ_LEN_DEF,
    parameter int PERIOD_W    = c_PERIOD_W_DEF,
    parameter int DUR_W       = c_DUR_W_DEF,
    parameter int TICK_CYCLES = c_TICK_CYCLES_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       loop_en,
    input  logic                       wr_en,
    input  logic [$clog2(SEQ_LEN)-1:0] wr_addr,
    input  logic [PERIOD_W-1:0]        wr_period,
    input  logic [DUR_W-1:0]           wr_dur,
    output logic                       jack,
    output logic                       busy,
    output logic [$clog2(SEQ_LEN)-1:0] step,
    output logic                       done
);

    localparam int c_ADDR_W = $clog2(SEQ_LEN);
    localparam int c_PRE_W  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [c_ADDR_W-1:0] c_LAST    = c_ADDR_W'(SEQ_LEN - 1);
    localparam logic [c_PRE_W-1:0]  c_PRE_MAX = c_PRE_W'(TICK_CYCLES - 1);

    typedef struct packed {
        logic [PERIOD_W-1:0] period;
        logic [DUR_W-1:0]    dur;
    } entry_t;

    entry_t              r_table_q [SEQ_LEN];

    state_t              r_state_q,  w_state_d;
    logic [c_ADDR_W-1:0] r_step_q,   w_step_d;
    logic [PERIOD_W-1:0] r_period_q, w_period_d;
    logic [DUR_W-1:0]    r_dur_q,    w_dur_d;
    logic [c_PRE_W-1:0]  r_pre_q,    w_pre_d;
    logic [DUR_W-1:0]    r_dcnt_q,   w_dcnt_d;
    logic                r_done_q,   w_done_d;

    logic                w_tick;
    logic                w_step_end;
    logic                w_load;
    logic [c_ADDR_W-1:0] w_load_addr;
    logic                w_restart;

    // Step table: not reset, written by software at any time.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_table_q[wr_addr] <= '{period: wr_period, dur: wr_dur};
        end
    end

    // Sequencing: step timing, step advance/wrap, stop and completion.
    always_comb begin
        w_state_d   = r_state_q;
        w_step_d    = r_step_q;
        w_period_d  = r_period_q;
        w_dur_d     = r_dur_q;
        w_pre_d     = r_pre_q;
        w_dcnt_d    = r_dcnt_q;
        w_done_d    = 1'b0;
        w_load      = 1'b0;
        w_load_addr = '0;

        w_tick     = (r_pre_q == c_PRE_MAX);
        // A zero-duration step is a one-cycle skip.
        w_step_end = (r_dur_q == '0) ||
                     (w_tick && (r_dcnt_q == r_dur_q - DUR_W'(1)));

        case (r_state_q)
            IDLE: begin
                if (start && !stop) begin
                    w_state_d   = PLAY;
                    w_load      = 1'b1;
                    w_load_addr = '0;
                end
            end
            PLAY: begin
                w_pre_d = w_tick ? '0 : r_pre_q + c_PRE_W'(1);
                if (w_tick) begin
                    w_dcnt_d = r_dcnt_q + DUR_W'(1);
                end
                if (stop) begin
                    w_state_d = IDLE;
                end else if (w_step_end) begin
                    if (r_step_q != c_LAST) begin
                        w_load      = 1'b1;
                        w_load_addr = r_step_q + c_ADDR_W'(1);
                    end else if (loop_en) begin
                        w_load      = 1'b1;
                        w_load_addr = '0;
                    end else begin
                        w_state_d = IDLE;
                        w_done_d  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase

        // Step entry: the table is read on the loading edge, so a write to
        // the same address at that edge is not seen until the next load.
        if (w_load) begin
            w_step_d   = w_load_addr;
            w_period_d = r_table_q[w_load_addr].period;
            w_dur_d    = r_table_q[w_load_addr].dur;
            w_pre_d    = '0;
            w_dcnt_d   = '0;
        end

        if (w_state_d == IDLE) begin
            w_step_d   = '0;
            w_period_d = '0;
            w_dur_d    = '0;
            w_pre_d    = '0;
            w_dcnt_d   = '0;
        end

        w_restart = w_load || (w_state_d == IDLE);
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q  <= IDLE;
            r_step_q   <= '0;
            r_period_q <= '0;
            r_dur_q    <= '0;
            r_pre_q    <= '0;
            r_dcnt_q   <= '0;
            r_done_q   <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_step_q   <= w_step_d;
            r_period_q <= w_period_d;
            r_dur_q    <= w_dur_d;
            r_pre_q    <= w_pre_d;
            r_dcnt_q   <= w_dcnt_d;
            r_done_q   <= w_done_d;
        end
    end

    tone_gen #(
        .PERIOD_W (PERIOD_W)
    ) u_tone_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .period  (r_period_q),
        .restart (w_restart),
        .jack    (jack)
    );

    assign busy = (r_state_q == PLAY);
    assign step = r_step_q;
    assign done = r_done_q;

endmodule
`default_nettype wire

// File: tb/tb_tone_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_tone_sequencer
// Brief   : Directed self-checking bench for tone_sequencer
//           (SEQ_LEN=4, PERIOD_W=8, DUR_W=4, TICK_CYCLES=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_tone_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       loop_en;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_period;
    logic [3:0] wr_dur;
    logic       jack;
    logic       busy;
    logic [1:0] step;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [127:0] jv, sv, bv, dv;

    tone_sequencer #(
        .SEQ_LEN     (4),
        .PERIOD_W    (8),
        .DUR_W       (4),
        .TICK_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .loop_en   (loop_en),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_period (wr_period),
        .wr_dur    (wr_dur),
        .jack      (jack),
        .busy      (busy),
        .step      (step),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // Advance one cycle; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chkv(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] p, input logic [3:0] d);
        wr_en     = 1'b1;
        wr_addr   = a;
        wr_period = p;
        wr_dur    = d;
        cyc();
        wr_en     = 1'b0;
    endtask

    // Record n cycles of outputs, oldest sample in the most significant bits.
    task automatic run(input int n, output logic [127:0] j, output logic [127:0] s,
                       output logic [127:0] b, output logic [127:0] d);
        j = '0; s = '0; b = '0; d = '0;
        for (int i = 0; i < n; i++) begin
            j = {j[126:0], jack};
            s = {s[125:0], step};
            b = {b[126:0], busy};
            d = {d[126:0], done};
            cyc();
        end
    endtask

    // One full pass of table {(2,2),(0,1),(1,1),(3,0)} starting at step 0.
    task automatic check_pass(input string pfx);
        run(17, jv, sv, bv, dv);
        chkv({pfx, "_jack"}, jv, 128'(17'b00110011_0000_0101_0));
        chkv({pfx, "_step"}, sv,
             128'(34'b00_00_00_00_00_00_00_00_01_01_01_01_10_10_10_10_11));
        chkv({pfx, "_busy"}, bv, 128'(17'h1FFFF));
        chkv({pfx, "_done"}, dv, 128'(0));
    endtask

    task automatic load_base_table();
        wr(2'd0, 8'd2, 4'd2);
        wr(2'd1, 8'd0, 4'd1);
        wr(2'd2, 8'd1, 4'd1);
        wr(2'd3, 8'd3, 4'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        int nj;
        int ns;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_period = '0; wr_dur = '0;
        repeat (3) cyc();
        chkv("rst_jack", 128'(jack), 128'(0));
        chkv("rst_busy", 128'(busy), 128'(0));
        chkv("rst_step", 128'(step), 128'(0));
        chkv("rst_done", 128'(done), 128'(0));
        rst_n = 1'b1;
        cyc();

        // 1: one-shot playback
        load_base_table();
        loop_en = 1'b0;
        pulse_start();
        check_pass("t1");
        chkv("t1_done_pulse", 128'({done, busy, step, jack}), 128'(5'b1_0_00_0));
        cyc();
        chkv("t1_done_clear", 128'({done, busy}), 128'(0));

        // 2: looping, then loop_en cleared during the second pass
        loop_en = 1'b1;
        pulse_start();
        check_pass("t2a");
        loop_en = 1'b0;
        check_pass("t2b");
        chkv("t2_done_pulse", 128'({done, busy, step}), 128'(4'b1_0_00));
        cyc();

        // 3: stop at cycle 5 of step 0, start+stop in IDLE, stop in step 1
        pulse_start();
        run(4, jv, sv, bv, dv);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chkv("t3_stop_outs", 128'({done, busy, step, jack}), 128'(0));
        run(3, jv, sv, bv, dv);
        chkv("t3_stop_nodone", dv | bv, 128'(0));
        start = 1'b1; stop = 1'b1;
        cyc();
        chkv("t3_start_stop_idle", 128'(busy), 128'(0));
        start = 1'b0; stop = 1'b0;
        cyc();
        pulse_start();
        run(9, jv, sv, bv, dv);
        chkv("t3_in_step1", 128'(step), 128'(1));
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chkv("t3_stop2_outs", 128'({done, busy, step, jack}), 128'(0));

        // 4: writes during playback
        loop_en = 1'b1;
        pulse_start();
        wr(2'd2, 8'd4, 4'd2);
        run(19, jv, sv, bv, dv);
        chkv("t4_jack", jv, 128'(19'b0110011_0000_00001111));
        chkv("t4_step", sv,
             128'(38'b00_00_00_00_00_00_00_01_01_01_01_10_10_10_10_10_10_10_10));
        chkv("t4_at_step3", 128'(step), 128'(3));
        wr(2'd0, 8'd5, 4'd1);
        run(8, jv, sv, bv, dv);
        chkv("t4_reload_jack", jv, 128'(8'b00110011));
        chkv("t4_reload_step", sv, 128'(0));
        chkv("t4_then_step1", 128'(step), 128'(1));
        stop = 1'b1;
        cyc();
        stop = 1'b0;

        // 5: reset mid-playback, table retained
        wr(2'd0, 8'd2, 4'd2);
        wr(2'd2, 8'd1, 4'd1);
        loop_en = 1'b1;
        pulse_start();
        run(9, jv, sv, bv, dv);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chkv("t5_rst_outs", 128'({done, busy, step, jack}), 128'(0));
        cyc();
        chkv("t5_rst_idle", 128'({done, busy}), 128'(0));
        loop_en = 1'b0;
        pulse_start();
        check_pass("t5");
        chkv("t5_done_pulse", 128'({done, busy}), 128'(2'b10));
        cyc();

        // 6: maximum field widths
        wr(2'd0, 8'd255, 4'd15);
        wr(2'd1, 8'd0, 4'd0);
        wr(2'd2, 8'd0, 4'd0);
        wr(2'd3, 8'd0, 4'd0);
        pulse_start();
        nj = 0;
        ns = 0;
        for (int i = 0; i < 60; i++) begin
            if (jack) nj++;
            if (step != 2'd0 || !busy) ns++;
            cyc();
        end
        chkv("t6_no_toggle", 128'(nj), 128'(0));
        chkv("t6_step0_len", 128'(ns), 128'(0));
        chkv("t6_step1", 128'({busy, step}), 128'(3'b1_01));
        cyc();
        chkv("t6_step2", 128'({busy, step}), 128'(3'b1_10));
        cyc();
        chkv("t6_step3", 128'({busy, step}), 128'(3'b1_11));
        cyc();
        chkv("t6_done", 128'({done, busy}), 128'(2'b10));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
